// File: rtl/uart_packet_tx_pkg.sv
// uart_packet_tx_pkg
//   Shared definitions for the UART packet framer: default payload depth,
//   default start marker, checksum width, FSM state encoding and the
//   checksum helper.
package uart_packet_tx_pkg;

    localparam int         BYTE_W        = 8;
    localparam int         SUM_W         = 8;
    localparam int         DEPTH_DEFAULT = 16;
    localparam logic [7:0] START_DEFAULT = 8'h7E;

    // S_* states emit one byte each; GAP is the single idle cycle after
    // every emitted byte; FIN pulses done and clears the buffer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        S_START = 3'd1,
        GAP     = 3'd2,
        S_LEN   = 3'd3,
        S_DATA  = 3'd4,
        S_SUM   = 3'd5,
        FIN     = 3'd6
    } state_t;

    // Checksum byte that brings LEN + payload + SUM to zero modulo 2^SUM_W.
    function automatic logic [SUM_W-1:0] checksum_of(input logic [SUM_W-1:0] acc);
        return {SUM_W{1'b0}} - acc;
    endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// uart_packet_tx_if
//   Byte-write handshake towards the UART transmitter.
//     uByte     : byte to transmit (UART cByte)
//     uWrite    : one-cycle write strobe (UART cWrite)
//     uCanWrite : UART can accept a byte (UART hCanWrite)
//   Handshake: uWrite is a one-cycle valid pulse; it is only launched on an
//   edge where uCanWrite (ready) was sampled high, and uByte is stable from
//   that pulse until the next one.  uCanWrite is not sampled in the cycle
//   following a pulse, which absorbs the UART's busy-flag latency.
//   master = framer side, slave = UART side.
interface uart_packet_tx_if;
    logic [uart_packet_tx_pkg::BYTE_W-1:0] uByte;
    logic                                  uWrite;
    logic                                  uCanWrite;

    modport master (output uByte, output uWrite, input uCanWrite);
    modport slave  (input uByte, input uWrite, output uCanWrite);
endinterface

// File: rtl/uart_packet_buffer.sv
// uart_packet_buffer
//   DEPTH x 8 payload register file for the packet framer.
//     clock, reset : clock and synchronous active-high reset
//     clear        : empty the buffer (pointers and count to zero)
//     push, wdata  : append wdata (caller guarantees not full)
//     pop          : advance the read pointer
//     rdata        : byte at the read pointer
//     rdPtr        : read pointer, one bit wider so it can reach DEPTH
//     count, full  : bytes buffered, count == DEPTH (both registered)
//   Pops only move the read pointer; count keeps the packet length until
//   the buffer is cleared.
module uart_packet_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   rdPtr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] WR_ONE   = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW:0]   countInc;

    assign countInc = count + CNT_ONE;
    assign rdata    = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + WR_ONE;
                count <= countInc;
                full  <= (countInc == FULL_COUNT);
            end
            if (pop) begin
                rdPtr <= rdPtr + CNT_ONE;
            end
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= wdata;
        end
    end
endmodule

// File: rtl/uart_packet_tx.sv
// uart_packet_tx
//   Packet framer: buffers payload bytes and, on send, writes
//   START, LEN, payload..., SUM to the UART one byte per handshake.
//     clock, reset : clock and synchronous active-high reset
//     inByte/inPush: append a payload byte (IDLE only, dropped when full
//                    or together with an accepted send)
//     inFull/count : buffer status
//     send         : start a packet (accepted in IDLE only)
//     busy         : packet in progress
//     done         : one-cycle pulse in the final cycle of a packet
//     dbgState     : current FSM state
//     uart         : byte-write handshake to the UART (master side)
module uart_packet_tx
    import uart_packet_tx_pkg::*;
#(
    parameter int         DEPTH = DEPTH_DEFAULT,
    parameter logic [7:0] START = START_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             inByte,
    input  logic                   inPush,
    output logic                   inFull,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   send,
    output logic                   busy,
    output logic                   done,
    output state_t                 dbgState,
    uart_packet_tx_if.master       uart
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    state_t           state, stateNext;
    state_t           retState, retStateNext;   // emit state to enter after GAP
    logic [AW:0]      len, lenNext;
    logic [SUM_W-1:0] sum, sumNext;
    logic             uWriteNext;
    logic [7:0]       uByteNext;
    logic             bufPush, bufPop, bufClear;
    logic [7:0]       bufData;
    logic [AW:0]      rdPtr;

    assign dbgState = state;
    assign bufPush  = (state == IDLE) && inPush && !send && !inFull;

    uart_packet_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clock (clock),
        .reset (reset),
        .clear (bufClear),
        .push  (bufPush),
        .wdata (inByte),
        .pop   (bufPop),
        .rdata (bufData),
        .rdPtr (rdPtr),
        .count (count),
        .full  (inFull)
    );

    always_comb begin
        stateNext    = state;
        retStateNext = retState;
        lenNext      = len;
        sumNext      = sum;
        uWriteNext   = 1'b0;
        uByteNext    = uart.uByte;
        bufPop       = 1'b0;
        bufClear     = 1'b0;
        case (state)
            IDLE: begin
                if (send) begin
                    stateNext = S_START;
                    lenNext   = count;
                    // Checksum accumulator starts at LEN.
                    sumNext   = SUM_W'(count);
                end
            end
            S_START: begin
                if (uart.uCanWrite) begin
                    uWriteNext   = 1'b1;
                    uByteNext    = START;
                    stateNext    = GAP;
                    retStateNext = S_LEN;
                end
            end
            S_LEN: begin
                if (uart.uCanWrite) begin
                    uWriteNext   = 1'b1;
                    uByteNext    = 8'(len);
                    stateNext    = GAP;
                    retStateNext = (len == '0) ? S_SUM : S_DATA;
                end
            end
            S_DATA: begin
                if (uart.uCanWrite) begin
                    uWriteNext   = 1'b1;
                    uByteNext    = bufData;
                    sumNext      = sum + bufData;
                    bufPop       = 1'b1;
                    stateNext    = GAP;
                    retStateNext = (rdPtr + PTR_ONE == len) ? S_SUM : S_DATA;
                end
            end
            S_SUM: begin
                if (uart.uCanWrite) begin
                    uWriteNext   = 1'b1;
                    uByteNext    = checksum_of(sum);
                    stateNext    = GAP;
                    retStateNext = FIN;
                end
            end
            GAP: begin
                stateNext = retState;
            end
            FIN: begin
                stateNext = IDLE;
                bufClear  = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // busy and done are registered copies of the next-state decode, so they
    // line up exactly with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            retState    <= IDLE;
            len         <= '0;
            sum         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            uart.uWrite <= 1'b0;
            uart.uByte  <= '0;
        end else begin
            state       <= stateNext;
            retState    <= retStateNext;
            len         <= lenNext;
            sum         <= sumNext;
            busy        <= (stateNext != IDLE);
            done        <= (stateNext == FIN);
            uart.uWrite <= uWriteNext;
            uart.uByte  <= uByteNext;
        end
    end
endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx
//   Bench for uart_packet_tx: directed scenarios plus randomized packets
//   with a toggling uCanWrite, checked against a queue-based frame model.
module tb_uart_packet_tx;
    import uart_packet_tx_pkg::*;

    localparam int         DEPTH = 16;
    localparam logic [7:0] START = 8'h7E;

    logic       clock;
    logic       reset;
    logic [7:0] inByte;
    logic       inPush;
    logic       inFull;
    logic [4:0] count;
    logic       send;
    logic       busy;
    logic       done;
    state_t     dbgState;

    uart_packet_tx_if u_if ();

    uart_packet_tx #(.DEPTH(DEPTH), .START(START)) dut (
        .clock    (clock),
        .reset    (reset),
        .inByte   (inByte),
        .inPush   (inPush),
        .inFull   (inFull),
        .count    (count),
        .send     (send),
        .busy     (busy),
        .done     (done),
        .dbgState (dbgState),
        .uart     (u_if)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int          cyc = 0;
    logic        can_at_edge = 1'b0;
    always @(posedge clock) begin
        cyc         <= cyc + 1;
        can_at_edge <= u_if.uCanWrite;
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];       // expected UART byte stream
    logic [7:0] model_buf[$];   // model of the payload buffer
    bit         model_busy = 1'b0;
    int         expected_done = 0;
    int         done_seen = 0;
    int         wr_cyc[$];
    int         done_cyc = 0;
    int         send_cyc = 0;
    bit         rand_can = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (done) done_seen++;
            if (u_if.uWrite) begin
                wr_cyc.push_back(cyc);
                check("write_without_can", 32'(can_at_edge), 32'd1);
                if (exp_q.size() == 0) begin
                    check("extra_write", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("uart_byte", 32'(u_if.uByte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Random ready generator, active only while rand_can is set.
    initial begin
        forever begin
            @(negedge clock);
            if (rand_can) u_if.uCanWrite = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b);
        @(negedge clock);
        inByte = b;
        inPush = 1'b1;
        @(negedge clock);
        inPush = 1'b0;
        if (!model_busy && model_buf.size() < DEPTH) model_buf.push_back(b);
        check("count_after_push", 32'(count), 32'(model_buf.size()));
        check("full_after_push", 32'(inFull), 32'(model_buf.size() == DEPTH));
    endtask

    // Builds the expected frame from the buffered model bytes.
    task automatic send_pkt();
        int acc;
        @(negedge clock);
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
        send_cyc = cyc;
        if (!model_busy) begin
            acc = model_buf.size();
            exp_q.push_back(START);
            exp_q.push_back(8'(model_buf.size()));
            foreach (model_buf[i]) begin
                exp_q.push_back(model_buf[i]);
                acc += model_buf[i];
            end
            exp_q.push_back(8'((256 - (acc % 256)) % 256));
            model_busy = 1'b1;
        end
        check("busy_after_send", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(done), 32'd1);
        if (seen) begin
            expected_done++;
            done_cyc = cyc;
        end
        check("frame_consumed", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_buf.delete();
        model_busy = 1'b0;
        @(negedge clock);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("count_cleared", 32'(count), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int seen;
        int len_try;
        reset  = 1'b1;
        inByte = 8'h00;
        inPush = 1'b0;
        send   = 1'b0;
        u_if.uCanWrite = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_uWrite", 32'(u_if.uWrite), 32'd0);
        check("rst_uByte", 32'(u_if.uByte), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(inFull), 32'd0);
        check("rst_state", 32'(dbgState), 32'(IDLE));

        // Two-byte packet with ready held high: timing of every pulse.
        push_byte(8'h68);
        push_byte(8'h69);
        wr_cyc.delete();
        send_pkt();
        wait_done(100);
        check("first_pulse_latency", 32'(wr_cyc.size() > 0 ? wr_cyc[0] - send_cyc : -1), 32'd1);
        check("pulse_count", 32'(wr_cyc.size()), 32'd5);
        for (int i = 1; i < wr_cyc.size(); i++) begin
            check("pulse_gap", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);
        end
        if (wr_cyc.size() > 0) check("packet_cycles", 32'(done_cyc - wr_cyc[0] + 1), 32'd10);

        // Empty packet.
        send_pkt();
        wait_done(100);

        // Full buffer plus a dropped 17th push.
        for (int i = 1; i <= 16; i++) push_byte(8'(i));
        check("full_flag", 32'(inFull), 32'd1);
        push_byte(8'hFF);
        send_pkt();
        wait_done(200);

        // Ready held low: no writes; pushes and send during busy ignored.
        push_byte(8'h41);
        u_if.uCanWrite = 1'b0;
        send_pkt();
        seen = wr_cyc.size();
        repeat (20) @(negedge clock);
        check("no_write_while_blocked", 32'(wr_cyc.size()), 32'(seen));
        check("busy_while_blocked", 32'(busy), 32'd1);
        push_byte(8'h99);
        send_pkt();
        check("count_during_busy", 32'(count), 32'd1);
        u_if.uCanWrite = 1'b1;
        wait_done(100);

        // Reset one cycle after the LEN write abandons the packet.
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        send_pkt();
        n    = 0;
        seen = 0;
        while (seen < 2 && n < 100) begin
            @(negedge clock);
            n++;
            if (u_if.uWrite) seen++;
        end
        check("len_write_reached", 32'(seen), 32'd2);
        @(negedge clock);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_buf.delete();
        model_busy = 1'b0;
        check("mid_rst_uWrite", 32'(u_if.uWrite), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_state", 32'(dbgState), 32'(IDLE));
        repeat (10) @(negedge clock);
        check("no_done_after_rst", 32'(done_seen), 32'(expected_done));
        push_byte(8'h55);
        send_pkt();
        wait_done(100);

        // Randomized packets with random ready.
        for (int p = 0; p < 8; p++) begin
            len_try = $urandom_range(0, 18);
            for (int i = 0; i < len_try; i++) push_byte(8'($urandom_range(0, 255)));
            rand_can = 1'b1;
            send_pkt();
            wait_done(600);
            rand_can = 1'b0;
            u_if.uCanWrite = 1'b1;
            @(negedge clock);
        end

        check("done_total", 32'(done_seen), 32'(expected_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
